// File: rtl/mac_accumulate.sv
// Pipelined signed multiply-accumulate: one product per accepted beat, up to MAX_TERMS terms per result.
// Optional build macro MAC_SATURATE_EN: clamp instead of wrap when the accumulator overflows.
module mac_accumulate #(
  parameter int IL        = 4,
  parameter int FL        = 16,
  parameter int MAX_TERMS = 16,
  localparam int W        = IL + FL,
  localparam int AW       = 4 + 2 * W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] acc_out,
  output logic          overflow
);

  localparam int CW = $clog2(MAX_TERMS + 1);

  typedef enum logic [1:0] {
    S_ACC   = 2'd0,
    S_FLUSH = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic signed [2*W-1:0] prod_q;
  logic                  p_valid_q;
  logic                  p_first_q;
  logic [AW-1:0]         acc_q;
  logic [AW-1:0]         acc_d;
  logic                  ovf_q;
  logic                  ovf_d;
  logic [AW-1:0]         acc_out_q;
  logic                  in_ready_q;
  logic                  out_valid_q;

  logic                  accept_s;
  logic                  last_s;
  logic                  handshake_s;
  logic signed [2*W-1:0] prod_s;
  logic [AW-1:0]         prod_ext_s;
  logic [AW:0]           sum_s;
  logic                  add_ovf_s;

`ifdef MAC_SATURATE_EN
  localparam logic [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};
  logic clamp_q;
  logic clamp_d;
`endif

  assign accept_s    = in_valid && in_ready_q;
  assign last_s      = in_last || (cnt_q == CW'(MAX_TERMS - 1));
  assign handshake_s = out_valid_q && out_ready;
  assign prod_s      = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
  assign prod_ext_s  = {{(AW-2*W){prod_q[2*W-1]}}, prod_q};
  // One extra bit exposes signed overflow as a mismatch of the top two sum bits.
  assign sum_s       = {acc_q[AW-1], acc_q} + {prod_ext_s[AW-1], prod_ext_s};
  assign add_ovf_s   = sum_s[AW] ^ sum_s[AW-1];

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;
  assign overflow  = ovf_q;

  // Accumulator next state: first product of a result replaces the running sum.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
`ifdef MAC_SATURATE_EN
    clamp_d = clamp_q;
`endif
    if (handshake_s) begin
      ovf_d = 1'b0;
    end else if (p_valid_q) begin
      if (p_first_q) begin
        acc_d = prod_ext_s;
`ifdef MAC_SATURATE_EN
        clamp_d = 1'b0;
`endif
      end else begin
`ifdef MAC_SATURATE_EN
        if (clamp_q) begin
          acc_d = acc_q;
        end else if (add_ovf_s) begin
          acc_d   = sum_s[AW] ? SAT_MIN : SAT_MAX;
          clamp_d = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          acc_d = sum_s[AW-1:0];
        end
`else
        acc_d = sum_s[AW-1:0];
        if (add_ovf_s) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
`endif
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Control FSM, product stage and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_ACC;
      cnt_q       <= '0;
      prod_q      <= '0;
      p_valid_q   <= 1'b0;
      p_first_q   <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      acc_out_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef MAC_SATURATE_EN
      clamp_q     <= 1'b0;
`endif
    end else begin
      p_valid_q <= accept_s;
      if (accept_s) begin
        prod_q    <= prod_s;
        p_first_q <= (cnt_q == CW'(0));
      end
      acc_q <= acc_d;
      ovf_q <= ovf_d;
`ifdef MAC_SATURATE_EN
      clamp_q <= clamp_d;
`endif
      case (state_q)
        S_ACC: begin
          if (accept_s) begin
            cnt_q <= cnt_q + CW'(1);
            if (last_s) begin
              state_q    <= S_FLUSH;
              in_ready_q <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          if (p_valid_q) begin
            state_q     <= S_OUT;
            out_valid_q <= 1'b1;
            acc_out_q   <= acc_d;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state_q     <= S_ACC;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
          end
        end
        default: begin
          state_q     <= S_ACC;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          cnt_q       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulate.sv
// Randomized self-checking bench for mac_accumulate against an arithmetic reference model.
module tb_mac_accumulate;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_last, out_ready;
  logic [19:0] a, b;
  logic        in_ready, out_valid, overflow;
  logic [43:0] acc_out;

  logic        in_valid2, in_last2, out_ready2;
  logic [19:0] a2, b2;
  logic        in_ready2, out_valid2, overflow2;
  logic [43:0] acc_out2;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [19:0] va [64];
  logic signed [19:0] vb [64];

  always #5 clk = ~clk;

  mac_accumulate dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .acc_out(acc_out), .overflow(overflow)
  );

  mac_accumulate #(.MAX_TERMS(64)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .in_last(in_last2), .out_valid(out_valid2),
    .out_ready(out_ready2), .acc_out(acc_out2), .overflow(overflow2)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer dot product with signed 44-bit range rules.
  task automatic model(input int n, output logic [63:0] exp_acc, output logic exp_ovf);
    longint acc, s, p;
    longint maxv, minv, modv;
`ifdef MAC_SATURATE_EN
    bit clamped;
    clamped = 1'b0;
`endif
    maxv = 64'sd8796093022207;
    minv = -64'sd8796093022208;
    modv = 64'sd17592186044416;
    acc = 0;
    exp_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      p = longint'(va[i]) * longint'(vb[i]);
      if (i == 0) begin
        acc = p;
      end else begin
        s = acc + p;
        if (s > maxv || s < minv) begin
          exp_ovf = 1'b1;
`ifdef MAC_SATURATE_EN
          if (!clamped) acc = (s > maxv) ? maxv : minv;
          clamped = 1'b1;
`else
          acc = (s > maxv) ? s - modv : s + modv;
`endif
        end else begin
`ifdef MAC_SATURATE_EN
          if (!clamped) acc = s;
`else
          acc = s;
`endif
        end
      end
    end
    exp_acc = 64'(acc) & 64'h0000_0FFF_FFFF_FFFF;
  endtask

  task automatic run_result(input int n, input bit give_last, input int stall, input bit gaps);
    logic [63:0] exp_acc;
    logic        exp_ovf;
    model(n, exp_acc, exp_ovf);
    check_eq("rdy_idle", 64'(in_ready), 64'd1);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      a        = va[i];
      b        = vb[i];
      in_last  = give_last && (i == n - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_eq("rdy_drop", 64'(in_ready), 64'd0);
    check_eq("ov_early", 64'(out_valid), 64'd0);
    tick();
    check_eq("ov_lat", 64'(out_valid), 64'd1);
    check_eq("acc", 64'(acc_out), exp_acc);
    check_eq("ovf", 64'(overflow), 64'(exp_ovf));
    for (int k = 0; k < stall; k++) begin
      tick();
      check_eq("hold_ov", 64'(out_valid), 64'd1);
      check_eq("hold_acc", 64'(acc_out), exp_acc);
      check_eq("hold_ovf", 64'(overflow), 64'(exp_ovf));
      check_eq("hold_rdy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("done_ov", 64'(out_valid), 64'd0);
    check_eq("done_rdy", 64'(in_ready), 64'd1);
    check_eq("done_ovf", 64'(overflow), 64'd0);
    check_eq("keep_acc", 64'(acc_out), exp_acc);
  endtask

  initial begin
    logic [63:0] exp_acc;
    logic        exp_ovf;
    int          n;
    bit          gl;

    reset = 1'b0;
    {in_valid, in_last, out_ready, a, b} = '0;
    {in_valid2, in_last2, out_ready2, a2, b2} = '0;
    tick();
    tick();
    check_eq("rst_ov", 64'(out_valid), 64'd0);
    check_eq("rst_acc", 64'(acc_out), 64'd0);
    check_eq("rst_ovf", 64'(overflow), 64'd0);
    reset = 1'b1;
    tick();
    check_eq("rst_rdy", 64'(in_ready), 64'd1);

    va[0] = 20'h10000; vb[0] = 20'h20000;
    run_result(1, 1'b1, 0, 1'b0);
    check_eq("one_x_two", 64'(acc_out), 64'h0000_0002_0000_0000);

    for (int i = 0; i < 3; i++) begin va[i] = 20'h10000; vb[i] = 20'hF0000; end
    run_result(3, 1'b1, 0, 1'b0);
    check_eq("neg_three", 64'(acc_out), 64'h0000_0FFD_0000_0000);

    for (int i = 0; i < 16; i++) begin va[i] = 20'h10000; vb[i] = 20'h10000; end
    run_result(16, 1'b0, 0, 1'b0);
    check_eq("forced_16", 64'(acc_out), 64'h0000_0010_0000_0000);

    for (int i = 0; i < 16; i++) begin va[i] = 20'h10000; vb[i] = 20'h10000; end
    run_result(16, 1'b1, 0, 1'b1);
    check_eq("last_on_16", 64'(acc_out), 64'h0000_0010_0000_0000);

    va[0] = 20'h30000; vb[0] = 20'h10000;
    va[1] = 20'h10000; vb[1] = 20'h10000;
    run_result(2, 1'b1, 5, 1'b0);
    check_eq("stall_five", 64'(acc_out), 64'h0000_0004_0000_0000);

    for (int r = 0; r < 25; r++) begin
      n  = $urandom_range(1, 16);
      gl = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        va[i] = 20'($urandom);
        vb[i] = 20'($urandom);
      end
      run_result(n, gl, $urandom_range(0, 3), 1'b1);
    end

    // Partial result abandoned by reset, then a clean single-term result.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = 20'h70000; b = 20'h50000; in_last = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_ov", 64'(out_valid), 64'd0);
    check_eq("mid_rst_acc", 64'(acc_out), 64'd0);
    check_eq("mid_rst_ovf", 64'(overflow), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    va[0] = 20'h10000; vb[0] = 20'h10000;
    run_result(1, 1'b1, 0, 1'b0);
    check_eq("post_rst", 64'(acc_out), 64'h0000_0001_0000_0000);

    for (int i = 0; i < 32; i++) begin va[i] = 20'h80000; vb[i] = 20'h80000; end
    model(32, exp_acc, exp_ovf);
    for (int i = 0; i < 32; i++) begin
      in_valid2 = 1'b1; a2 = 20'h80000; b2 = 20'h80000; in_last2 = (i == 31);
      tick();
    end
    in_valid2 = 1'b0;
    in_last2  = 1'b0;
    check_eq("ovf64_rdy", 64'(in_ready2), 64'd0);
    tick();
    check_eq("ovf64_ov", 64'(out_valid2), 64'd1);
    check_eq("ovf64_flag", 64'(overflow2), 64'd1);
    check_eq("ovf64_model", 64'(acc_out2), exp_acc);
`ifdef MAC_SATURATE_EN
    check_eq("ovf64_acc", 64'(acc_out2), 64'h0000_07FF_FFFF_FFFF);
`else
    check_eq("ovf64_acc", 64'(acc_out2), 64'h0000_0800_0000_0000);
`endif
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    check_eq("ovf64_rdy2", 64'(in_ready2), 64'd1);
    check_eq("ovf64_clr", 64'(overflow2), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_accumulate.md
MAC_ACCUMULATE -- requirements
Module: mac_accumulate

Interface
REQ-001 SHALL have parameter IL, default 4, integer bits of each operand; W = IL+FL.
REQ-002 SHALL have parameter FL, default 16, fraction bits of each operand; AW = 4+2*W.
REQ-003 SHALL have parameter MAX_TERMS, default 16, maximum products per result.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, operand pair valid.
REQ-007 SHALL have port in_ready, output, 1, block accepts operand pair.
REQ-008 SHALL have port a, input, W, signed operand, Q(IL).(FL).
REQ-009 SHALL have port b, input, W, signed operand, Q(IL).(FL).
REQ-010 SHALL have port in_last, input, 1, beat is final term of current dot product.
REQ-011 SHALL have port out_valid, output, 1, acc_out holds a finished sum.
REQ-012 SHALL have port out_ready, input, 1, downstream rounding stage accepts result.
REQ-013 SHALL have port acc_out, output, AW, signed sum, Q(4+2*IL).(2*FL), feeds the stochastic rounding stage input.
REQ-014 SHALL have port overflow, output, 1, sticky: accumulation overflowed AW bits during the current result.

Function
REQ-015 SHALL accept a beat when in_valid && in_ready at a clock edge.
REQ-016 SHALL register the full signed product a*b (2*W bits) one cycle after acceptance (stage P).
REQ-017 SHALL add the sign-extended stage-P product to the accumulator one cycle after stage P; the first product of a result replaces the accumulator.
REQ-018 SHALL implement states ACC, FLUSH, OUT; in_ready = 1 only in ACC.
REQ-019 SHALL transition ACC->FLUSH on accepting a beat with in_last=1 or on the MAX_TERMS-th accepted beat (forced last).
REQ-020 SHALL transition FLUSH->OUT once the final product has been added; out_valid asserts exactly 2 cycles after the last beat is accepted.
REQ-021 SHALL hold acc_out and overflow stable while out_valid && !out_ready.
REQ-022 SHALL transition OUT->ACC on out_valid && out_ready; out_valid deasserts and in_ready asserts in the next cycle; term count and overflow clear.
REQ-023 SHALL set overflow when any addition's true result falls outside the signed AW range.
REQ-024 SHALL keep acc_out equal to the last valid result between results; do not compare it when out_valid is 0.
REQ-025 SHALL count terms 1..MAX_TERMS; an explicit in_last on the MAX_TERMS-th beat is one result, not two.

Reset
REQ-026 SHALL, while reset=0, force state ACC, in_ready=1 (after release), out_valid=0, acc_out=0, overflow=0, term count=0, and stage P empty, regardless of the current state.
REQ-027 SHALL discard any partial sum or pending result when reset asserts mid-operation.

Configuration
REQ-028 SHALL, with macro MAC_SATURATE_EN defined, clamp an overflowing sum to 2^(AW-1)-1 or -2^(AW-1) and keep it clamped for the rest of the result.
REQ-029 SHALL, without MAC_SATURATE_EN, wrap the sum modulo 2^AW; overflow is still flagged.

Verification
REQ-030 SHALL cover: single beat a=0x10000 (1.0), b=0x20000 (2.0), in_last=1 -> out_valid 2 cycles later, acc_out=0x200000000, overflow=0.
REQ-031 SHALL cover: 3 beats a=0x10000, b=0xF0000 (-1.0), last on beat 3 -> acc_out=-3*2^32 (0xFFD00000000), overflow=0.
REQ-032 SHALL cover: 16 beats a=b=0x10000, in_last never asserted -> in_ready drops after beat 16, acc_out=0x1000000000.
REQ-033 SHALL cover: MAX_TERMS=64, 32 beats a=b=0x80000 (-8.0) -> overflow=1; acc_out=0x7FFFFFFFFFF with MAC_SATURATE_EN, 0x80000000000 without.
REQ-034 SHALL cover: result ready, out_ready held 0 for 5 cycles -> out_valid=1, acc_out/overflow unchanged, in_ready=0, each cycle; accept on cycle 6 -> in_ready=1 next cycle.
REQ-035 SHALL cover: 2 beats accepted then reset pulsed low -> outputs zero; then one beat a=b=0x10000, last -> acc_out=0x100000000 only.
